tm_scan_ctrl: RTL and testbench
===============================

Name: tm_scan_ctrl

Overview:
- Sequences the template-matching datapath and owns the full-frame binary line buffer and the SAD unit.
- Streams one thresholded frame into the line buffer, then steps the buffer one pixel at a time so the window moves through every valid template position in raster order.
- At each valid position it starts a SAD comparison, then records the minimum SAD and its (x,y) coordinates.
- Sits between the grayscale thresholding stage (upstream) and the line buffer / SAD unit (downstream).

Parameters:
- IMG_W, 640, image width in pixels
- IMG_H, 480, image height in pixels
- TPL_W, 40, template width
- TPL_H, 100, template height
- SAD_W, 12, SAD result width (must hold TPL_W*TPL_H)
- XW, 10, x coordinate width
- YW, 9, y coordinate width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- start  in  1  one-cycle pulse; begins a frame
- pix_valid  in  1  upstream pixel available
- pix_data  in  1  upstream binary pixel
- pix_ready  out  1  pixel accepted this cycle (pix_valid && pix_ready = transfer)
- lb_d  out  1  serial data to line buffer
- lb_ena  out  1  line-buffer shift control, active-low: 0 = shift on this edge, 1 = hold
- sad_start  out  1  one-cycle pulse; window is stable, begin SAD
- sad_done  in  1  one-cycle pulse; sad_value valid
- sad_value  in  SAD_W  SAD result for the current window
- busy  out  1  frame in progress
- done  out  1  scan complete; results valid
- best_sad  out  SAD_W  minimum SAD found
- best_x  out  XW  x of minimum
- best_y  out  YW  y of minimum

Behaviour:
- Reset (rst=0, async): state IDLE; all counters 0.
  - Outputs at reset: pix_ready=0, lb_ena=1, lb_d=0, sad_start=0, busy=0, done=0, best_sad=all-ones, best_x=0, best_y=0.
- States: IDLE, FILL, EVAL, WAIT, STEP, DONE.
- IDLE/DONE + start:
  - Go to FILL.
  - Clear done, best_sad := all-ones, best_x/best_y := 0.
  - Clear fill counter, x, y.
- start in FILL/EVAL/WAIT/STEP: ignored.
- FILL:
  - pix_ready=1; lb_d=pix_data; lb_ena = ~pix_valid, so the buffer shifts only on a transfer.
  - Fill counter increments per transfer.
  - After transfer number IMG_W*IMG_H, go to EVAL with x=0, y=0.
  - While pix_valid=0, hold with no shift.
- EVAL: sad_start=1 for exactly one cycle, lb_ena=1; go to WAIT.
- WAIT:
  - lb_ena=1 (window frozen).
  - On sad_done, if sad_value < best_sad (strict): load best_sad, best_x=x, best_y=y. Ties keep the earlier raster position.
  - Then, if x==IMG_W-TPL_W and y==IMG_H-TPL_H, go to DONE; otherwise go to STEP.
  - sad_done outside WAIT is ignored.
- STEP:
  - lb_ena=0, lb_d=0 (padding shift; upstream not consumed, pix_ready=0).
  - x := x+1, wrapping from IMG_W-1 to 0 with y := y+1.
  - Next state: EVAL if the new x <= IMG_W-TPL_W; otherwise STEP again, so row-end positions are skipped by consecutive shifts.
- DONE: done=1, busy=0, best_* held until the next start.
- busy=1 in FILL, EVAL, WAIT, STEP.
- Counts:
  - Evaluations per frame = (IMG_W-TPL_W+1)*(IMG_H-TPL_H+1); default 601*381 = 228981.
  - Shifts per frame = IMG_W*IMG_H + (IMG_H-TPL_H)*IMG_W + (IMG_W-TPL_W).
- Latency: the first sad_start occurs exactly 1 cycle after the final fill transfer edge. Each subsequent sad_start follows the previous sad_done by 1 STEP cycle plus 1 cycle per skipped column, then the EVAL cycle.
- Reset mid-frame: immediate return to IDLE with reset values; no sad_start is issued.

Test Plan:
- Use IMG_W=8, IMG_H=6, TPL_W=3, TPL_H=2 unless stated.
- Reset idle: assert rst=0 mid-FILL after 20 pixels -> next cycle busy=0, lb_ena=1, pix_ready=0, best_sad=all-ones; a subsequent start runs a full 48-pixel fill.
- Nominal scan: start, 48 pixels with pix_valid always 1; SAD model returns 10 everywhere except 3 at (4,2) -> exactly 30 sad_start pulses, total lb_ena=0 count = 48+32+5 = 85, done=1, best=(3,4,2).
- Ties/minimum: SAD returns 5 at (1,0) and at (2,3), 9 elsewhere -> best_x=1, best_y=0, best_sad=5.
- Backpressure: pix_valid toggled 1,0,1,0 during fill -> lb_ena=0 only on transfer cycles; exactly 48 fill shifts; first sad_start 1 cycle after the 48th transfer.
- SAD latency: sad_done delayed 0..7 cycles randomly, plus a spurious sad_done in STEP -> lb_ena stays 1 throughout WAIT; spurious pulse has no effect; still 30 evaluations.
- Restart: start pulse while busy -> ignored; start in DONE -> best_sad resets to all-ones and a new fill begins.

Source files
------------

// File: rtl/tm_scan_ctrl.sv
// rtl/tm_scan_ctrl.sv - template-match scan sequencer: frame fill, window stepping, min-SAD tracking
// Fills the binary line buffer, walks every valid window position in raster order and keeps the best SAD.
module tm_scan_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int TPL_W = 40,
  parameter int TPL_H = 100,
  parameter int SAD_W = 12,
  parameter int XW    = 10,
  parameter int YW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pix_valid,
  input  logic             pix_data,
  output logic             pix_ready,
  output logic             lb_d,
  output logic             lb_ena,
  output logic             sad_start,
  input  logic             sad_done,
  input  logic [SAD_W-1:0] sad_value,
  output logic             busy,
  output logic             done,
  output logic [SAD_W-1:0] best_sad,
  output logic [XW-1:0]    best_x,
  output logic [YW-1:0]    best_y
);

  localparam int NPIX = IMG_W * IMG_H;
  localparam int FCW  = $clog2(NPIX + 1);

  localparam logic [FCW-1:0] FILL_LAST = FCW'(NPIX - 1);
  localparam logic [XW-1:0]  X_LAST    = XW'(IMG_W - 1);
  localparam logic [XW-1:0]  X_MAX     = XW'(IMG_W - TPL_W);
  localparam logic [YW-1:0]  Y_MAX     = YW'(IMG_H - TPL_H);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_EVAL,
    S_WAIT,
    S_STEP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [FCW-1:0]   fill_q, fill_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic [XW-1:0]    best_x_q, best_x_d;
  logic [YW-1:0]    best_y_q, best_y_d;

  logic             xfer;
  logic             last_pos;
  logic             x_wrap;
  logic [XW-1:0]    x_inc;

  assign xfer     = (state_q == S_FILL) && pix_valid;
  assign last_pos = (x_q == X_MAX) && (y_q == Y_MAX);
  assign x_wrap   = (x_q == X_LAST);
  assign x_inc    = x_wrap ? '0 : x_q + XW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fill_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      best_sad_q <= '1;
      best_x_q   <= '0;
      best_y_q   <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      x_q        <= x_d;
      y_q        <= y_d;
      best_sad_q <= best_sad_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_d     = fill_q;
    x_d        = x_q;
    y_d        = y_q;
    best_sad_d = best_sad_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_FILL;
          fill_d     = '0;
          x_d        = '0;
          y_d        = '0;
          best_sad_d = '1;
          best_x_d   = '0;
          best_y_d   = '0;
        end
      end
      S_FILL: begin
        if (xfer) begin
          fill_d = fill_q + FCW'(1);
          if (fill_q == FILL_LAST) begin
            state_d = S_EVAL;
            x_d     = '0;
            y_d     = '0;
          end
        end
      end
      S_EVAL: state_d = S_WAIT;
      S_WAIT: begin
        if (sad_done) begin
          // strict compare keeps the earliest raster position on ties
          if (sad_value < best_sad_q) begin
            best_sad_d = sad_value;
            best_x_d   = x_q;
            best_y_d   = y_q;
          end
          state_d = last_pos ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        x_d = x_inc;
        if (x_wrap) begin
          y_d = y_q + YW'(1);
        end
        // columns past X_MAX have no full window; keep shifting through them
        state_d = (x_inc <= X_MAX) ? S_EVAL : S_STEP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pix_ready = 1'b0;
    lb_d      = 1'b0;
    lb_ena    = 1'b1;
    sad_start = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_FILL: begin
        pix_ready = 1'b1;
        lb_d      = pix_data;
        lb_ena    = ~pix_valid;
        busy      = 1'b1;
      end
      S_EVAL: begin
        sad_start = 1'b1;
        busy      = 1'b1;
      end
      S_WAIT: busy = 1'b1;
      S_STEP: begin
        lb_ena = 1'b0;
        busy   = 1'b1;
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign best_sad = best_sad_q;
  assign best_x   = best_x_q;
  assign best_y   = best_y_q;

endmodule

// File: tb/tb_tm_scan_ctrl.sv
// tb/tb_tm_scan_ctrl.sv - directed bench for tm_scan_ctrl on an 8x6 image with a 3x2 template
module tb_tm_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pix_valid;
  logic        pix_data;
  logic        pix_ready;
  logic        lb_d;
  logic        lb_ena;
  logic        sad_start;
  logic        sad_done = 1'b0;
  logic [11:0] sad_value = '0;
  logic        busy;
  logic        done;
  logic [11:0] best_sad;
  logic [9:0]  best_x;
  logic [8:0]  best_y;

  int vectors = 0;
  int errors  = 0;

  int cyc = 0;
  int shifts, fill_shifts, xfers, fill_err, wait_err, evals;
  int last_xfer, first_start;
  int mode = 0;
  int max_dly = 0;
  bit spurious_en = 1'b0;
  bit spur_done;
  bit pend = 1'b0;
  int dly = 0;
  logic [11:0] val = '0;

  tm_scan_ctrl #(
    .IMG_W(8), .IMG_H(6), .TPL_W(3), .TPL_H(2), .SAD_W(12), .XW(10), .YW(9)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .lb_d(lb_d), .lb_ena(lb_ena), .sad_start(sad_start),
    .sad_done(sad_done), .sad_value(sad_value), .busy(busy), .done(done),
    .best_sad(best_sad), .best_x(best_x), .best_y(best_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] sad_model(input int m, input int x, input int y);
    if (m == 0) return (x == 4 && y == 2) ? 12'd3 : 12'd10;
    return ((x == 1 && y == 0) || (x == 2 && y == 3)) ? 12'd5 : 12'd9;
  endfunction

  // monitor plus SAD responder; runs after the stimulus has settled for this cycle
  always @(negedge clk) begin
    #2;
    if (rst) begin
      if (!lb_ena) shifts++;
      if (pix_ready) begin
        if (pix_valid) begin
          xfers++;
          last_xfer = cyc;
          if (lb_ena !== 1'b0 || lb_d !== pix_data) fill_err++;
        end else if (lb_ena !== 1'b1) fill_err++;
        if (!lb_ena) fill_shifts++;
      end else if (!lb_ena && lb_d !== 1'b0) fill_err++;
      if (pend && lb_ena !== 1'b1) wait_err++;
      sad_done = 1'b0;
      if (pend) begin
        if (dly == 0) begin
          sad_done  = 1'b1;
          sad_value = val;
          pend      = 1'b0;
        end else dly--;
      end else if (spurious_en && !spur_done && busy && !pix_ready && !lb_ena) begin
        sad_done  = 1'b1;
        sad_value = 12'd0;
        spur_done = 1'b1;
      end
      if (sad_start) begin
        if (evals == 0) first_start = cyc;
        pend = 1'b1;
        dly  = (max_dly > 0) ? int'($urandom_range(0, max_dly)) : 0;
        val  = sad_model(mode, evals % 6, evals / 6);
        evals++;
      end
    end else begin
      sad_done = 1'b0;
      pend     = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    shifts = 0; fill_shifts = 0; xfers = 0; fill_err = 0; wait_err = 0; evals = 0;
    last_xfer = -100; first_start = -1; spur_done = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic feed(input int n, input bit toggle);
    int got = 0;
    int guard = 0;
    bit ph = 1'b0;
    while (got < n && guard < 1000) begin
      @(negedge clk);
      pix_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      pix_data = 1'($urandom_range(0, 1));
      #1;
      if (pix_valid && pix_ready) got++;
      guard++;
    end
    @(negedge clk); pix_valid = 1'b0;
    check("feed_count", got, n);
  endtask

  task automatic wait_done();
    int g = 0;
    while (!done && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("done_reached", done, 1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_data = 1'b0;
    clear_counts();
    repeat (3) @(negedge clk);
    #1;
    check("rst_pix_ready", pix_ready, 0);
    check("rst_lb_ena", lb_ena, 1);
    check("rst_lb_d", lb_d, 0);
    check("rst_sad_start", sad_start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_best_sad", best_sad, 12'hfff);
    check("rst_best_x", best_x, 0);
    check("rst_best_y", best_y, 0);
    rst = 1'b1;

    // reset in the middle of the fill
    pulse_start();
    #1;
    check("fill_busy", busy, 1);
    feed(20, 1'b0);
    rst = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_lb_ena", lb_ena, 1);
    check("midrst_pix_ready", pix_ready, 0);
    check("midrst_best_sad", best_sad, 12'hfff);
    @(negedge clk); rst = 1'b1;
    check("midrst_no_eval", evals, 0);

    // nominal scan
    clear_counts(); mode = 0;
    pulse_start();
    feed(48, 1'b0);
    wait_done();
    check("nom_evals", evals, 30);
    check("nom_shifts", shifts, 85);
    check("nom_fill_shifts", fill_shifts, 48);
    check("nom_latency", first_start - last_xfer, 1);
    check("nom_busy", busy, 0);
    check("nom_best_sad", best_sad, 3);
    check("nom_best_x", best_x, 4);
    check("nom_best_y", best_y, 2);
    check("nom_lane_err", fill_err, 0);

    // ties keep the earliest position; start from DONE clears results
    clear_counts(); mode = 1;
    pulse_start();
    #1;
    check("restart_best_sad", best_sad, 12'hfff);
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    feed(48, 1'b0);
    wait_done();
    check("tie_evals", evals, 30);
    check("tie_best_sad", best_sad, 5);
    check("tie_best_x", best_x, 1);
    check("tie_best_y", best_y, 0);

    // backpressure during fill
    clear_counts(); mode = 0;
    pulse_start();
    feed(48, 1'b1);
    wait_done();
    check("bp_xfers", xfers, 48);
    check("bp_fill_shifts", fill_shifts, 48);
    check("bp_lane_err", fill_err, 0);
    check("bp_latency", first_start - last_xfer, 1);
    check("bp_shifts", shifts, 85);
    check("bp_best_x", best_x, 4);

    // random SAD latency, spurious sad_done in STEP, start while busy
    clear_counts(); mode = 0; max_dly = 7; spurious_en = 1'b1;
    pulse_start();
    feed(48, 1'b0);
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    check("busy_start_busy", busy, 1);
    check("busy_start_kept", best_sad == 12'hfff, 0);
    wait_done();
    check("lat_spur_seen", spur_done, 1);
    check("lat_wait_err", wait_err, 0);
    check("lat_evals", evals, 30);
    check("lat_shifts", shifts, 85);
    check("lat_best_sad", best_sad, 3);
    check("lat_best_x", best_x, 4);
    check("lat_best_y", best_y, 2);
    spurious_en = 1'b0; max_dly = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
